wb_port_arbiter: RTL

//  Write-back arbiter in front of the 4-write-port GPR/HILO register file. Collects

---
 rtl/wb_port_arbiter_pkg.sv | 32 +++
 rtl/wb_port_arbiter_scan.sv | 49 ++++
 rtl/wb_port_arbiter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared widths, constants and the write-port payload type for the
// write-back arbiter in front of the 4-write-port GPR/HILO register file.
package wb_port_arbiter_pkg;

  localparam int REG_ADDR_W = 6;
  localparam int WB_DATA_W  = 64;
  localparam int WB_PORTS   = 4;

  localparam logic [REG_ADDR_W-1:0] HILO_ADDR    = 6'd32;
  localparam logic [REG_ADDR_W-1:0] DISCARD_ADDR = 6'd0;

  // One register-file write port as seen at the output register.
  typedef struct packed {
    logic                  we;
    logic [REG_ADDR_W-1:0] waddr;
    logic [WB_DATA_W-1:0]  wdata;
  } wb_port_t;

  // Index of the port chosen for a write.
  typedef logic [1:0] port_idx_t;

  // True for addresses that never occupy a write port.
  function automatic logic is_discard(input logic [REG_ADDR_W-1:0] addr);
    return addr == DISCARD_ADDR;
  endfunction

  // True for the HILO pseudo-register, which may only use port 0.
  function automatic logic is_hilo(input logic [REG_ADDR_W-1:0] addr);
    return addr == HILO_ADDR;
  endfunction

endpackage

// File: rtl/wb_port_arbiter_scan.sv
// Builds the per-cycle scan order of requesters: starved requesters first in
// ascending index order, then every other requester in rotated order starting
// at rr_ptr. Each index appears exactly once in the list.
module rr_scan_order
  import wb_port_arbiter_pkg::*;
#(
  parameter int REQ_N = 6,
  parameter int IDX_W = (REQ_N > 1) ? $clog2(REQ_N) : 1
) (
  input  logic [IDX_W-1:0]             rr_ptr_i,
  input  logic [REQ_N-1:0]             starved_i,
  output logic [REQ_N-1:0][IDX_W-1:0]  order_o,
  output logic [REQ_N-1:0]             order_starved_o
);

  localparam int SW = IDX_W + 1;

  logic [IDX_W-1:0] pos;
  logic [SW-1:0]    sum;
  logic [IDX_W-1:0] rot_idx;

  // Two passes fill the list: starved entries, then the rotated remainder.
  always_comb begin
    order_o         = '0;
    order_starved_o = '0;
    pos             = '0;
    sum             = '0;
    rot_idx         = '0;
    for (int i = 0; i < REQ_N; i++) begin
      if (starved_i[i]) begin
        order_o[pos]         = IDX_W'(i);
        order_starved_o[pos] = 1'b1;
        pos                  = pos + 1'b1;
      end
    end
    for (int k = 0; k < REQ_N; k++) begin
      sum = {1'b0, rr_ptr_i} + SW'(k);
      if (sum >= SW'(REQ_N)) begin
        sum = sum - SW'(REQ_N);
      end
      rot_idx = sum[IDX_W-1:0];
      if (!starved_i[rot_idx]) begin
        order_o[pos] = rot_idx;
        pos          = pos + 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Write-back arbiter: packs up to four functional-unit results per cycle onto
// the register-file write ports. HILO (addr 32) is restricted to port 0, GPR
// writes prefer ports 1..3, address 0 is accepted and discarded. Round-robin
// fairness with a starvation override; write ports are registered.
//
// Handshake: a requester transfers in a cycle when req_valid[i] & req_ready[i]
// are both high at the posedge. Requesters keep valid/addr/data stable until
// accepted. req_ready is combinational and may depend on req_valid; it is low
// during reset and while wb_hold is high.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int REQ_N      = 6,
  parameter int STARVE_LIM = 7
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        wb_hold,
  input  logic [REQ_N-1:0]            req_valid,
  input  logic [REQ_N*REG_ADDR_W-1:0] req_waddr,
  input  logic [REQ_N*WB_DATA_W-1:0]  req_wdata,
  output logic [REQ_N-1:0]            req_ready,
  output logic                        we0,
  output logic                        we1,
  output logic                        we2,
  output logic                        we3,
  output logic [REG_ADDR_W-1:0]       waddr0,
  output logic [REG_ADDR_W-1:0]       waddr1,
  output logic [REG_ADDR_W-1:0]       waddr2,
  output logic [REG_ADDR_W-1:0]       waddr3,
  output logic [WB_DATA_W-1:0]        wdata0,
  output logic [WB_DATA_W-1:0]        wdata1,
  output logic [WB_DATA_W-1:0]        wdata2,
  output logic [WB_DATA_W-1:0]        wdata3
);

  localparam int IDX_W  = (REQ_N > 1) ? $clog2(REQ_N) : 1;
  localparam int WAIT_W = $clog2(STARVE_LIM + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIM);

  // Registered state.
  wb_port_t [WB_PORTS-1:0]          port_q, port_d;
  logic [IDX_W-1:0]                 rr_ptr_q, rr_ptr_d;
  logic [REQ_N-1:0][WAIT_W-1:0]     wait_q, wait_d;

  // Scan order and arbitration results.
  logic [REQ_N-1:0]                 starved;
  logic [REQ_N-1:0][IDX_W-1:0]      order;
  logic [REQ_N-1:0]                 order_starved;
  logic [REQ_N-1:0]                 grant;
  logic                             active;
  logic                             ns_hit;
  logic [IDX_W-1:0]                 ns_last;

  // Per-entry scratch for the unrolled fill loop.
  logic [IDX_W-1:0]                 cur_idx;
  logic [REG_ADDR_W-1:0]            cur_addr;
  logic [WB_DATA_W-1:0]             cur_data;
  logic                             cur_ok;
  logic                             cur_uses_port;
  logic                             cur_conflict;
  port_idx_t                        cur_port;
  logic [WB_PORTS-1:0]              port_used;

  assign active = resetn && !wb_hold;

  // A requester is starved once its stall counter saturates.
  always_comb begin
    for (int i = 0; i < REQ_N; i++) begin
      starved[i] = (wait_q[i] == WAIT_MAX);
    end
  end

  rr_scan_order #(
    .REQ_N (REQ_N),
    .IDX_W (IDX_W)
  ) u_scan (
    .rr_ptr_i        (rr_ptr_q),
    .starved_i       (starved),
    .order_o         (order),
    .order_starved_o (order_starved)
  );

  // Walk the scan order, granting ports and rejecting conflicts and overflow.
  always_comb begin
    grant         = '0;
    port_used     = '0;
    ns_hit        = 1'b0;
    ns_last       = '0;
    cur_idx       = '0;
    cur_addr      = '0;
    cur_data      = '0;
    cur_ok        = 1'b0;
    cur_uses_port = 1'b0;
    cur_conflict  = 1'b0;
    cur_port      = '0;
    for (int k = 0; k < WB_PORTS; k++) begin
      port_d[k]    = port_q[k];
      port_d[k].we = 1'b0;
    end
    for (int s = 0; s < REQ_N; s++) begin
      cur_idx       = order[s];
      cur_addr      = req_waddr[int'(cur_idx)*REG_ADDR_W +: REG_ADDR_W];
      cur_data      = req_wdata[int'(cur_idx)*WB_DATA_W +: WB_DATA_W];
      cur_ok        = 1'b0;
      cur_uses_port = 1'b0;
      cur_conflict  = 1'b0;
      cur_port      = '0;
      if (active && req_valid[cur_idx]) begin
        if (is_discard(cur_addr)) begin
          cur_ok = 1'b1;
        end else begin
          for (int k = 0; k < WB_PORTS; k++) begin
            if (port_used[k] && port_d[k].waddr == cur_addr) begin
              cur_conflict = 1'b1;
            end
          end
          if (!cur_conflict) begin
            if (is_hilo(cur_addr)) begin
              if (!port_used[0]) begin
                cur_ok = 1'b1; cur_uses_port = 1'b1; cur_port = 2'd0;
              end
            end else if (!port_used[1]) begin
              cur_ok = 1'b1; cur_uses_port = 1'b1; cur_port = 2'd1;
            end else if (!port_used[2]) begin
              cur_ok = 1'b1; cur_uses_port = 1'b1; cur_port = 2'd2;
            end else if (!port_used[3]) begin
              cur_ok = 1'b1; cur_uses_port = 1'b1; cur_port = 2'd3;
            end else if (!port_used[0]) begin
              cur_ok = 1'b1; cur_uses_port = 1'b1; cur_port = 2'd0;
            end
          end
        end
      end
      if (cur_ok) begin
        grant[cur_idx] = 1'b1;
        if (cur_uses_port) begin
          port_used[cur_port]    = 1'b1;
          port_d[cur_port].we    = 1'b1;
          port_d[cur_port].waddr = cur_addr;
          port_d[cur_port].wdata = cur_data;
        end
        if (!order_starved[s]) begin
          ns_hit  = 1'b1;
          ns_last = cur_idx;
        end
      end
    end
  end

  assign req_ready = grant;

  // Next round-robin pointer and stall counters; only committed when not held.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (ns_hit) begin
      rr_ptr_d = (ns_last == IDX_W'(REQ_N - 1)) ? '0 : ns_last + 1'b1;
    end
    for (int i = 0; i < REQ_N; i++) begin
      if (!req_valid[i] || grant[i]) begin
        wait_d[i] = '0;
      end else if (wait_q[i] != WAIT_MAX) begin
        wait_d[i] = wait_q[i] + 1'b1;
      end else begin
        wait_d[i] = wait_q[i];
      end
    end
  end

  // Output port register plus arbitration state.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      port_q   <= '0;
      rr_ptr_q <= '0;
      wait_q   <= '0;
    end else begin
      port_q <= port_d;
      if (!wb_hold) begin
        rr_ptr_q <= rr_ptr_d;
        wait_q   <= wait_d;
      end
    end
  end

  assign we0    = port_q[0].we;
  assign we1    = port_q[1].we;
  assign we2    = port_q[2].we;
  assign we3    = port_q[3].we;
  assign waddr0 = port_q[0].waddr;
  assign waddr1 = port_q[1].waddr;
  assign waddr2 = port_q[2].waddr;
  assign waddr3 = port_q[3].waddr;
  assign wdata0 = port_q[0].wdata;
  assign wdata1 = port_q[1].wdata;
  assign wdata2 = port_q[2].wdata;
  assign wdata3 = port_q[3].wdata;

endmodule
